// File: rtl/fifo_word_packer_if.sv
// Bus bundle for the word packer: upstream show-ahead FIFO read port,
// flush request, and the downstream valid/ready packed-word stream.
interface fifo_word_packer_if #(
   parameter int DATA_WIDTH = 8,
   parameter int PACK       = 4
);
   logic                         fifo_empty;
   logic [DATA_WIDTH-1:0]        fifo_rdata;
   logic                         fifo_r_en;
   logic                         flush;
   logic                         m_valid;
   logic                         m_ready;
   logic [DATA_WIDTH*PACK-1:0]   m_data;
   logic [PACK-1:0]              m_keep;

   // The packer: pops the FIFO and sources the packed-word stream.
   modport master (
      input  fifo_empty, fifo_rdata, flush, m_ready,
      output fifo_r_en, m_valid, m_data, m_keep
   );

   // The surroundings: FIFO, flush source and downstream sink.
   modport slave (
      output fifo_empty, fifo_rdata, flush, m_ready,
      input  fifo_r_en, m_valid, m_data, m_keep
   );
endinterface

// File: rtl/fifo_word_packer.sv
// Packs PACK consecutive entries of a show-ahead FIFO into one wide word.
// Entry order is preserved (first popped entry lands in lane 0); a flush
// pulse emits a partially filled word with m_keep marking the live lanes.
// A full word is handed to the one-word output register in the same cycle
// that the next entry is popped, so sustained throughput is one entry/cycle.
module fifo_word_packer #(
   parameter int DATA_WIDTH = 8,
   parameter int PACK       = 4
) (
   input  logic                  rclk,
   input  logic                  rrst_n,
   fifo_word_packer_if.master    bus
);

   localparam int                 CNT_W    = $clog2(PACK + 1);
   localparam int                 WORD_W   = DATA_WIDTH * PACK;
   localparam logic [CNT_W-1:0]   CNT_FULL = CNT_W'(PACK);

   logic [CNT_W-1:0]  cnt;
   logic              flush_pend;
   logic [WORD_W-1:0] pack_q;
   logic              out_free;
   logic              load;
   logic              pop;
   logic [CNT_W-1:0]  wr_lane;

   // Keep mask with the lowest n bits set, i.e. (2^n)-1.
   function automatic logic [PACK-1:0] keep_mask(input logic [CNT_W-1:0] n);
      logic [PACK-1:0] m;
      m = '0;
      for (int k = 0; k < PACK; k++) begin
         if (k < int'(n)) m[k] = 1'b1;
      end
      return m;
   endfunction

   // Expand a per-lane keep mask to a per-bit data mask so stale lanes read zero.
   function automatic logic [WORD_W-1:0] lane_mask(input logic [PACK-1:0] keep);
      logic [WORD_W-1:0] m;
      m = '0;
      for (int k = 0; k < PACK; k++) begin
         m[k*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{keep[k]}};
      end
      return m;
   endfunction

   assign out_free = !bus.m_valid || bus.m_ready;
   assign load     = out_free && ((cnt == CNT_FULL) || (flush_pend && (cnt != '0)));
   // Pops stop during reset, in the flush cycle and while a flush is pending.
   assign pop      = rrst_n && !bus.fifo_empty && !bus.flush && !flush_pend &&
                     ((cnt < CNT_FULL) || load);
   assign bus.fifo_r_en = pop;
   // A pop coinciding with a load starts the next word in lane 0.
   assign wr_lane  = load ? '0 : cnt;

   // Pack register, entry count and flush bookkeeping.
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         cnt        <= '0;
         flush_pend <= 1'b0;
         pack_q     <= '0;
      end else begin
         if (pop) begin
            pack_q[int'(wr_lane)*DATA_WIDTH +: DATA_WIDTH] <= bus.fifo_rdata;
         end
         if (load) begin
            cnt <= pop ? CNT_W'(1) : '0;
         end else if (pop) begin
            cnt <= cnt + CNT_W'(1);
         end
         // A pending flush retires on its load, or at once if nothing was packed.
         if (flush_pend) begin
            if (load || (cnt == '0)) flush_pend <= 1'b0;
         end else if (bus.flush) begin
            flush_pend <= 1'b1;
         end
      end
   end

   // One-word output register: loads a packed word, holds it until accepted.
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         bus.m_valid <= 1'b0;
         bus.m_data  <= '0;
         bus.m_keep  <= '0;
      end else begin
         if (load) begin
            bus.m_data  <= pack_q & lane_mask(keep_mask(cnt));
            bus.m_keep  <= keep_mask(cnt);
            bus.m_valid <= 1'b1;
         end else if (bus.m_ready) begin
            bus.m_valid <= 1'b0;
         end
      end
   end

endmodule
